// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the Mini-SRC datapath: fetch plus a decoded instruction subset.
// Outputs are a pure decode of present state and opcode; clr forces T0 and silences every strobe.
module control_unit #(
    parameter logic [4:0] ALU_ADD = 5'd3,
    parameter logic [4:0] INC_PC  = 5'd14
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        MD_Read,
    output logic        ReadRAM,
    output logic        WriteRAM,
    output logic [4:0]  Control_Signals,
    output logic        run,
    output logic [3:0]  present_state
);

    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        T7   = 4'd7,
        HALT = 4'd15
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_HALT = 5'b11010;

    // Load-strobe and bus-source bit positions
    localparam int EN_Y   = 17;
    localparam int EN_Z   = 18;
    localparam int EN_PC  = 20;
    localparam int EN_MDR = 21;
    localparam int EN_IR  = 24;
    localparam int EN_MAR = 25;
    localparam int EN_OUT = 27;
    localparam int BS_RF  = 0;
    localparam int BS_ZLO = 19;
    localparam int BS_PC  = 20;
    localparam int BS_MDR = 21;
    localparam int BS_IN  = 22;
    localparam int BS_C   = 23;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] w_op;
    logic       w_alu3;
    logic       w_imm;
    logic       w_mem;
    logic       w_unused_ir;

    assign w_op        = ir[31:27];
    assign w_unused_ir = ^ir[26:0];
    assign w_alu3      = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) || (w_op == OP_OR);
    assign w_imm       = (w_op == OP_ADDI) || (w_op == OP_LDI);
    assign w_mem       = (w_op == OP_LD) || (w_op == OP_ST);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) r_state <= T0;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = T0;
        case (r_state)
            T0:      w_next = T1;
            T1:      w_next = T2;
            T2:      w_next = T3;
            T3: begin
                if (w_alu3 || w_imm || w_mem) w_next = T4;
                else if (w_op == OP_HALT)     w_next = HALT;
                else                          w_next = T0;
            end
            T4:      w_next = T5;
            T5:      w_next = w_mem ? T6 : T0;
            T6:      w_next = T7;
            T7:      w_next = T0;
            HALT:    w_next = HALT;
            default: w_next = T0;
        endcase
    end

    always_comb begin
        enable          = '0;
        busSelect       = '0;
        Gra             = 1'b0;
        Grb             = 1'b0;
        Grc             = 1'b0;
        Rin             = 1'b0;
        Rout            = 1'b0;
        BAout           = 1'b0;
        MD_Read         = 1'b0;
        ReadRAM         = 1'b0;
        WriteRAM        = 1'b0;
        Control_Signals = '0;
        if (!clr) begin
            case (r_state)
                T0: begin
                    busSelect[BS_PC] = 1'b1;
                    enable[EN_MAR]   = 1'b1;
                    enable[EN_Z]     = 1'b1;
                    Control_Signals  = INC_PC;
                end
                T1: begin
                    busSelect[BS_ZLO] = 1'b1;
                    enable[EN_PC]     = 1'b1;
                    enable[EN_MDR]    = 1'b1;
                    MD_Read           = 1'b1;
                    ReadRAM           = 1'b1;
                end
                T2: begin
                    busSelect[BS_MDR] = 1'b1;
                    enable[EN_IR]     = 1'b1;
                end
                T3: begin
                    if (w_alu3 || (w_op == OP_ADDI)) begin
                        Grb = 1'b1; Rout = 1'b1; busSelect[BS_RF] = 1'b1; enable[EN_Y] = 1'b1;
                    end else if ((w_op == OP_LDI) || w_mem) begin
                        // Base-address read so that R0 as base contributes zero
                        Grb = 1'b1; BAout = 1'b1; busSelect[BS_RF] = 1'b1; enable[EN_Y] = 1'b1;
                    end else if (w_op == OP_JR) begin
                        Gra = 1'b1; Rout = 1'b1; busSelect[BS_RF] = 1'b1; enable[EN_PC] = 1'b1;
                    end else if (w_op == OP_OUT) begin
                        Gra = 1'b1; Rout = 1'b1; busSelect[BS_RF] = 1'b1; enable[EN_OUT] = 1'b1;
                    end else if (w_op == OP_IN) begin
                        busSelect[BS_IN] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                end
                T4: begin
                    enable[EN_Z] = 1'b1;
                    if (w_alu3) begin
                        Grc = 1'b1; Rout = 1'b1; busSelect[BS_RF] = 1'b1;
                        Control_Signals = w_op;
                    end else begin
                        busSelect[BS_C] = 1'b1;
                        Control_Signals = ALU_ADD;
                    end
                end
                T5: begin
                    busSelect[BS_ZLO] = 1'b1;
                    if (w_mem) enable[EN_MAR] = 1'b1;
                    else begin Gra = 1'b1; Rin = 1'b1; end
                end
                T6: begin
                    enable[EN_MDR] = 1'b1;
                    if (w_op == OP_ST) begin
                        Gra = 1'b1; Rout = 1'b1; busSelect[BS_RF] = 1'b1;
                    end else begin
                        MD_Read = 1'b1; ReadRAM = 1'b1;
                    end
                end
                T7: begin
                    if (w_op == OP_ST) WriteRAM = 1'b1;
                    else begin busSelect[BS_MDR] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                end
                default: ;
            endcase
        end
    end

    assign run           = (r_state != HALT);
    assign present_state = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: checks every step's strobes against hand-built constants.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic [31:0] enable, busSelect;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, MD_Read, ReadRAM, WriteRAM;
    logic [4:0]  Control_Signals;
    logic        run;
    logic [3:0]  present_state;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] EY = 32'h1 << 17, EZ = 32'h1 << 18, EPC = 32'h1 << 20, EMDR = 32'h1 << 21;
    localparam logic [31:0] EIR = 32'h1 << 24, EMAR = 32'h1 << 25, EOUT = 32'h1 << 27;
    localparam logic [31:0] BRF = 32'h1, BZLO = 32'h1 << 19, BPC = 32'h1 << 20, BMDR = 32'h1 << 21;
    localparam logic [31:0] BIN = 32'h1 << 22, BC = 32'h1 << 23;
    // misc = {Gra,Grb,Grc,Rin,Rout,BAout,MD_Read,ReadRAM,WriteRAM}
    localparam logic [8:0] GRA = 9'h100, GRB = 9'h080, GRC = 9'h040, RIN = 9'h020, ROUT = 9'h010;
    localparam logic [8:0] BA = 9'h008, MDRD = 9'h004, RR = 9'h002, WR = 9'h001;

    control_unit dut (
        .clk(clk), .clr(clr), .ir(ir), .enable(enable), .busSelect(busSelect),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .MD_Read(MD_Read), .ReadRAM(ReadRAM), .WriteRAM(WriteRAM),
        .Control_Signals(Control_Signals), .run(run), .present_state(present_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] st, input logic rn, input logic [31:0] en,
                       input logic [31:0] bs, input logic [8:0] misc, input logic [4:0] cs);
        logic [82:0] obs, exp;
        obs = {present_state, run, enable, busSelect,
               {Gra, Grb, Grc, Rin, Rout, BAout, MD_Read, ReadRAM, WriteRAM}, Control_Signals};
        exp = {st, rn, en, bs, misc, cs};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        checks++;
        assert ($countones(busSelect) <= 1) else begin
            failures++;
            $error("FAIL %s_onehot: observed busSelect %h expected at most one bit", tag, busSelect);
        end
        checks++;
        assert ($countones({Gra, Grb, Grc}) <= 1) else begin
            failures++;
            $error("FAIL %s_gr: observed %b expected at most one of Gra/Grb/Grc", tag, {Gra, Grb, Grc});
        end
    endtask

    task automatic fetch(input string tag, input logic [31:0] instr);
        chk({tag, "_T0"}, 4'd0, 1'b1, EMAR | EZ, BPC, 9'h0, 5'd14);
        tick();
        chk({tag, "_T1"}, 4'd1, 1'b1, EPC | EMDR, BZLO, MDRD | RR, 5'd0);
        tick();
        ir = instr;
        chk({tag, "_T2"}, 4'd2, 1'b1, EIR, BMDR, 9'h0, 5'd0);
        tick();
    endtask

    task automatic alu3(input string tag, input logic [31:0] instr, input logic [4:0] op);
        fetch(tag, instr);
        chk({tag, "_T3"}, 4'd3, 1'b1, EY, BRF, GRB | ROUT, 5'd0);
        tick();
        chk({tag, "_T4"}, 4'd4, 1'b1, EZ, BRF, GRC | ROUT, op);
        tick();
        chk({tag, "_T5"}, 4'd5, 1'b1, 32'h0, BZLO, GRA | RIN, 5'd0);
        tick();
    endtask

    initial begin
        clr = 1'b1;
        ir  = 32'h0;
        tick();
        chk("reset", 4'd0, 1'b1, 32'h0, 32'h0, 9'h0, 5'd0);
        tick();
        clr = 1'b0;
        #1;

        // clr pulse in the middle of an add
        fetch("pre", 32'h18910000);
        chk("pre_T3", 4'd3, 1'b1, EY, BRF, GRB | ROUT, 5'd0);
        tick();
        chk("pre_T4", 4'd4, 1'b1, EZ, BRF, GRC | ROUT, 5'd3);
        clr = 1'b1;
        #1;
        chk("clr_mid", 4'd0, 1'b1, 32'h0, 32'h0, 9'h0, 5'd0);
        tick();
        chk("clr_hold", 4'd0, 1'b1, 32'h0, 32'h0, 9'h0, 5'd0);
        clr = 1'b0;
        #1;

        // add/sub/and/or, each returning to T0 at the sixth cycle
        alu3("add", 32'h18910000, 5'd3);
        alu3("sub", 32'h20000000, 5'd4);
        alu3("and", 32'h48000000, 5'd9);
        alu3("or",  32'h50000000, 5'd10);

        fetch("addi", 32'h58000000);
        chk("addi_T3", 4'd3, 1'b1, EY, BRF, GRB | ROUT, 5'd0);
        tick();
        chk("addi_T4", 4'd4, 1'b1, EZ, BC, 9'h0, 5'd3);
        tick();
        chk("addi_T5", 4'd5, 1'b1, 32'h0, BZLO, GRA | RIN, 5'd0);
        tick();

        fetch("ldi", 32'h08000000);
        chk("ldi_T3", 4'd3, 1'b1, EY, BRF, GRB | BA, 5'd0);
        tick();
        chk("ldi_T4", 4'd4, 1'b1, EZ, BC, 9'h0, 5'd3);
        tick();
        chk("ldi_T5", 4'd5, 1'b1, 32'h0, BZLO, GRA | RIN, 5'd0);
        tick();

        // ld R1,0x65(R2)
        fetch("ld", 32'h00900065);
        chk("ld_T3", 4'd3, 1'b1, EY, BRF, GRB | BA, 5'd0);
        tick();
        chk("ld_T4", 4'd4, 1'b1, EZ, BC, 9'h0, 5'd3);
        tick();
        chk("ld_T5", 4'd5, 1'b1, EMAR, BZLO, 9'h0, 5'd0);
        tick();
        chk("ld_T6", 4'd6, 1'b1, EMDR, 32'h0, MDRD | RR, 5'd0);
        tick();
        chk("ld_T7", 4'd7, 1'b1, 32'h0, BMDR, GRA | RIN, 5'd0);
        tick();

        // st 0x1F(R0),R4
        fetch("st", 32'h1200001F);
        chk("st_T3", 4'd3, 1'b1, EY, BRF, GRB | BA, 5'd0);
        tick();
        chk("st_T4", 4'd4, 1'b1, EZ, BC, 9'h0, 5'd3);
        tick();
        chk("st_T5", 4'd5, 1'b1, EMAR, BZLO, 9'h0, 5'd0);
        tick();
        chk("st_T6", 4'd6, 1'b1, EMDR, BRF, GRA | ROUT, 5'd0);
        tick();
        chk("st_T7", 4'd7, 1'b1, 32'h0, 32'h0, WR, 5'd0);
        tick();

        // jr R6, out R3, in
        fetch("jr", 32'h9B000000);
        chk("jr_T3", 4'd3, 1'b1, EPC, BRF, GRA | ROUT, 5'd0);
        tick();
        fetch("out", 32'hB1800000);
        chk("out_T3", 4'd3, 1'b1, EOUT, BRF, GRA | ROUT, 5'd0);
        tick();
        fetch("in", 32'hA8800000);
        chk("in_T3", 4'd3, 1'b1, 32'h0, BIN, GRA | RIN, 5'd0);
        tick();

        // nop and an unlisted opcode both idle for T3
        fetch("nop", 32'hC8000000);
        chk("nop_T3", 4'd3, 1'b1, 32'h0, 32'h0, 9'h0, 5'd0);
        tick();
        fetch("unl", 32'hF8000000);
        chk("unl_T3", 4'd3, 1'b1, 32'h0, 32'h0, 9'h0, 5'd0);
        tick();

        // halt: parks until clr
        fetch("halt", 32'hD0000000);
        chk("halt_T3", 4'd3, 1'b1, 32'h0, 32'h0, 9'h0, 5'd0);
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("halt_hold", 4'd15, 1'b0, 32'h0, 32'h0, 9'h0, 5'd0);
            tick();
        end
        clr = 1'b1;
        #1;
        chk("halt_clr", 4'd0, 1'b1, 32'h0, 32'h0, 9'h0, 5'd0);
        tick();
        clr = 1'b0;
        #1;
        ir = 32'h0;
        fetch("post", 32'h18910000);
        chk("post_T3", 4'd3, 1'b1, EY, BRF, GRB | ROUT, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
